md5_round_seq: RTL
==================

# md5_round_seq

Round sequencer for the MD5 compression core. Accepts a block-start request and steps the round index through 0..63, one round per datapath acknowledge. For every round it presents the round index, the message-word index g and the round-function select. These feed the shift-amount and constant lookups and the round datapath. It signals block completion, supports stall and abort, and keeps a count of completed blocks.

## Interface
- No parameters; widths are fixed by MD5.
- clk_i  in  1  clock; all logic on the rising edge
- rst_i  in  1  reset; synchronous, active-high
- start_i  in  1  request to begin a 64-round block
- ready_o  out  1  sequencer can accept start_i this cycle
- abort_i  in  1  cancel the block in progress
- adv_i  in  1  datapath consumed the current round; advance
- step_o  out  1  round outputs valid
- round_o  out  6  current round 0..63
- g_o  out  4  message word index for round_o
- func_o  out  2  round function select: 0=F, 1=G, 2=H, 3=I
- done_o  out  1  one-cycle pulse after the final round is consumed
- blocks_o  out  16  completed-block count; wraps modulo 2^16

## Operation
- States: IDLE, RUN, DONE.
- IDLE
  - ready_o=1, step_o=0.
  - start_i → RUN with round=0.
- RUN
  - step_o=1.
  - adv_i=1 with round<63: round+1.
  - adv_i=0: round_o, g_o and func_o hold.
  - adv_i=1 with round=63: go to DONE and increment blocks_o.
- DONE
  - Lasts one cycle; done_o=1, ready_o=0.
  - Next state is IDLE.
- abort_i in RUN → IDLE next cycle: no done_o, blocks_o unchanged, round_o=0. abort_i beats a simultaneous adv_i.
- abort_i in IDLE or DONE is ignored.
- start_i is ignored whenever ready_o=0.
- func_o = round_o[5:4].
- g_o is computed on the low 4 bits; all products are taken mod 16:
  - func 0: round
  - func 1: 5·round+1
  - func 2: 3·round+5
  - func 3: 7·round
- g_o and func_o are combinational from the round register, so they are valid in the same cycle as round_o.
- Reset values: state=IDLE, round_o=0, g_o=0, func_o=0, step_o=0, done_o=0, blocks_o=0, ready_o=1.
- rst_i in the middle of a block returns to the reset values on the next edge, with no done_o.

## Timing
- Start accepted at edge N → step_o=1 and round_o=0 from cycle N+1.
- With adv_i held high: the final advance is at N+64 and done_o=1 during cycle N+65.
- ready_o returns at N+66 (without burst).
- blocks_o updates on the same edge on which done_o rises.
- Each adv_i=0 cycle delays everything after it by exactly one cycle.

## Configuration
- MD5_SEQ_BURST_EN defined:
  - ready_o=1 also in RUN while round=63 and adv_i=1.
  - start_i accepted then → next cycle RUN with round=0, done_o=1 and blocks_o incremented; DONE is skipped.
  - Back-to-back blocks therefore run 64 cycles apart.
  - abort_i in that same cycle wins: go to IDLE and drop the start.
- MD5_SEQ_BURST_EN undefined: the DONE bubble is always taken; ready_o is 1 only in IDLE.

## Structure
- Shared package (defines.h):
  - state encodings SEQ_IDLE, SEQ_RUN, SEQ_DONE
  - function select codes FUNC_F/G/H/I
  - MD5_ROUNDS=64
  - g multiplier/offset constants (1/0, 5/1, 3/5, 7/0)
- Sub-module md5_gidx: combinational round → g_o; reused by any future unrolled datapath.

## Test plan
- Reset, then idle 5 cycles → ready_o=1, step_o=0, round_o=0, blocks_o=0 throughout.
- Start at cycle 0, adv_i always 1:
  - round 17 → g_o=6, func_o=1; round 33 → g_o=8, func_o=2; round 49 → g_o=7, func_o=3; round 63 → g_o=9.
  - done_o in cycle 65 only; blocks_o=1.
- Start, adv_i=0 in rounds 10 and 40 → round_o holds 10 and 40 for two cycles each; done_o at cycle 67.
- abort_i in round 20 with adv_i=1 → IDLE next cycle, round_o=0, no done_o, blocks_o unchanged; a new start then runs normally.
- Burst test, macro defined: start held high → second block's round_o=0 in the same cycle as done_o; blocks_o=2 after 128 advances. Macro undefined: one DONE cycle with ready_o=0 between the two blocks.
- rst_i asserted at round 30 → all outputs at reset values after the edge; blocks_o=0xFFFF plus one completion wraps to 0.

Source files
------------

// File: rtl/md5_round_seq_pkg.sv
// Shared definitions for the MD5 round sequencer: state encodings, round
// function select codes, round count and the per-function g multiplier/offset.
package md5_round_seq_pkg;

    typedef enum logic [1:0] {
        SEQ_IDLE = 2'd0,
        SEQ_RUN  = 2'd1,
        SEQ_DONE = 2'd2
    } seq_state_t;

    localparam logic [1:0] FUNC_F = 2'd0;
    localparam logic [1:0] FUNC_G = 2'd1;
    localparam logic [1:0] FUNC_H = 2'd2;
    localparam logic [1:0] FUNC_I = 2'd3;

    localparam int         MD5_ROUNDS = 64;
    localparam logic [5:0] LAST_ROUND = 6'(MD5_ROUNDS - 1);

    // g = (mult * round + offset) mod 16, one pair per round function
    localparam logic [3:0] G_MULT_F = 4'd1;
    localparam logic [3:0] G_OFF_F  = 4'd0;
    localparam logic [3:0] G_MULT_G = 4'd5;
    localparam logic [3:0] G_OFF_G  = 4'd1;
    localparam logic [3:0] G_MULT_H = 4'd3;
    localparam logic [3:0] G_OFF_H  = 4'd5;
    localparam logic [3:0] G_MULT_I = 4'd7;
    localparam logic [3:0] G_OFF_I  = 4'd0;

    function automatic logic [3:0] g_mult(input logic [1:0] func);
        case (func)
            FUNC_F:  return G_MULT_F;
            FUNC_G:  return G_MULT_G;
            FUNC_H:  return G_MULT_H;
            default: return G_MULT_I;
        endcase
    endfunction

    function automatic logic [3:0] g_offset(input logic [1:0] func);
        case (func)
            FUNC_F:  return G_OFF_F;
            FUNC_G:  return G_OFF_G;
            FUNC_H:  return G_OFF_H;
            default: return G_OFF_I;
        endcase
    endfunction

endpackage

// File: rtl/md5_gidx.sv
// Combinational round index -> message word index g and round function select.
// Kept separate so an unrolled datapath can instantiate one per round.
module md5_gidx
    import md5_round_seq_pkg::*;
(
    input  logic [5:0] round,
    output logic [3:0] g,
    output logic [1:0] func
);

    // Function is the round's quarter; g arithmetic is done in 4 bits so it wraps mod 16
    always_comb begin
        func = round[5:4];
        g    = g_mult(round[5:4]) * round[3:0] + g_offset(round[5:4]);
    end

endmodule

// File: rtl/md5_round_seq.sv
// MD5 round sequencer: steps rounds 0..63 on datapath acknowledges, flags
// block completion and counts completed blocks.
// Optional feature: define MD5_SEQ_BURST_EN to let a new block start on the
// final advance of the current one, skipping the DONE bubble.
module md5_round_seq
    import md5_round_seq_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    output logic        ready_o,
    input  logic        abort_i,
    input  logic        adv_i,
    output logic        step_o,
    output logic [5:0]  round_o,
    output logic [3:0]  g_o,
    output logic [1:0]  func_o,
    output logic        done_o,
    output logic [15:0] blocks_o
);

`ifdef MD5_SEQ_BURST_EN
    localparam bit BURST_EN = 1'b1;
`else
    localparam bit BURST_EN = 1'b0;
`endif

    seq_state_t  state;
    seq_state_t  state_next;
    logic [5:0]  round_q;
    logic [5:0]  round_next;
    logic [15:0] blocks_q;
    logic [15:0] blocks_next;
    logic        done_q;
    logic        done_next;
    logic        at_last;

    md5_gidx u_gidx (
        .round (round_q),
        .g     (g_o),
        .func  (func_o)
    );

    // Next-state, round and counter update; abort outranks advance, advance outranks burst start
    always_comb begin
        state_next  = state;
        round_next  = round_q;
        blocks_next = blocks_q;
        done_next   = 1'b0;
        at_last     = (round_q == LAST_ROUND);
        ready_o     = (state == SEQ_IDLE) ||
                      (BURST_EN && (state == SEQ_RUN) && adv_i && at_last);
        step_o      = (state == SEQ_RUN);
        case (state)
            SEQ_IDLE: begin
                if (start_i) begin
                    state_next = SEQ_RUN;
                    round_next = '0;
                end
            end
            SEQ_RUN: begin
                if (abort_i) begin
                    state_next = SEQ_IDLE;
                    round_next = '0;
                end else if (adv_i) begin
                    if (at_last) begin
                        blocks_next = blocks_q + 16'd1;
                        done_next   = 1'b1;
                        round_next  = '0;
                        if (BURST_EN && start_i) begin
                            state_next = SEQ_RUN;
                        end else begin
                            state_next = SEQ_DONE;
                        end
                    end else begin
                        round_next = round_q + 6'd1;
                    end
                end
            end
            SEQ_DONE: begin
                state_next = SEQ_IDLE;
            end
            default: begin
                state_next = SEQ_IDLE;
                round_next = '0;
            end
        endcase
    end

    // State, round, done pulse and block count registers with synchronous reset
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state    <= SEQ_IDLE;
            round_q  <= '0;
            blocks_q <= '0;
            done_q   <= 1'b0;
        end else begin
            state    <= state_next;
            round_q  <= round_next;
            blocks_q <= blocks_next;
            done_q   <= done_next;
        end
    end

    assign round_o  = round_q;
    assign done_o   = done_q;
    assign blocks_o = blocks_q;

endmodule
